// File: rtl/data_memory_lanes_if.sv
// Request/response bus for data_memory_lanes.
//   master : drives the request (valid, we, size, uns, addr, wdata), sees ready and the response
//   slave  : the memory; drives req_ready and the registered response (valid, rdata, err)
interface data_memory_lanes_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_lanes.sv
// data_memory_lanes: byte-lane data memory with byte/half/word loads and stores.
// Ports:
//   clock : single clock, all state updates on posedge
//   reset : synchronous, active-high
//   bus   : data_memory_lanes_if.slave (valid/ready request, one-cycle registered response)
// After reset an optional sweep writes zero to every word (one word per cycle)
// before the block starts accepting requests.  Storage is four 8-bit lane
// arrays sharing one address, so partial stores need no read-modify-write.
module data_memory_lanes #(
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic clock,
  input  logic reset,
  data_memory_lanes_if.slave bus
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            clear_we;
  logic            ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_EN) state_reg <= ST_CLEAR;
      else          state_reg <= ST_READY;
      idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    clear_we   = 1'b0;
    ready      = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clear_we = ~reset;
        idx_next = idx_reg + 1'b1;
        if (idx_reg == AW'(DEPTH - 1)) state_next = ST_READY;
      end
      ST_READY: begin
        // Gated by reset so req_ready reads 0 while reset is held, even with no sweep.
        ready = ~reset;
      end
      default: state_next = state_reg;
    endcase
  end

  // ---------------- request decode ----------------
  logic [AW-1:0] word_idx;
  logic [1:0]    off;
  logic          req_err;
  logic          accept;
  logic          do_store;
  logic          do_load;
  logic [3:0]    lane_mask;
  logic [31:0]   wr_data;
  logic [AW-1:0] ram_addr;
  logic          unused_addr;

  assign word_idx    = bus.req_addr[AW+1:2];
  assign off         = bus.req_addr[1:0];
  assign unused_addr = ^bus.req_addr[31:AW+2];

  always_comb begin
    req_err = 1'b0;
    case (bus.req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = off[0];
      2'b10:   req_err = (off != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  assign accept   = bus.req_valid & ready;
  assign do_store = accept & ~req_err & bus.req_we;
  assign do_load  = accept & ~req_err & ~bus.req_we;

  // Store data is replicated across lanes so each lane just takes its own slice.
  always_comb begin
    lane_mask = 4'b0000;
    wr_data   = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        lane_mask = 4'b0001 << off;
        wr_data   = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = off[1] ? 4'b1100 : 4'b0011;
        wr_data   = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        lane_mask = 4'b1111;
        wr_data   = bus.req_wdata;
      end
      default: begin
        lane_mask = 4'b0000;
        wr_data   = bus.req_wdata;
      end
    endcase
  end

  assign ram_addr = clear_we ? idx_reg : word_idx;

  // ---------------- lane arrays ----------------
  logic [31:0] rd_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;
      logic       lane_we;
      logic [7:0] lane_wd;

      assign lane_we = clear_we | (do_store & lane_mask[gi]);
      assign lane_wd = clear_we ? 8'h00 : wr_data[8*gi +: 8];

      always_ff @(posedge clock) begin
        if (lane_we) mem[ram_addr] <= lane_wd;
        if (do_load) rd_reg <= mem[ram_addr];
      end

      assign rd_word[8*gi +: 8] = rd_reg;
    end
  endgenerate

  // ---------------- response ----------------
  // Request attributes are captured only on accept, so the formatted read
  // data and err hold their last value between responses.
  logic       rsp_valid_reg;
  logic       rsp_err_reg;
  logic       is_load_reg;
  logic [1:0] size_reg;
  logic [1:0] off_reg;
  logic       uns_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      is_load_reg   <= 1'b0;
      size_reg      <= 2'b00;
      off_reg       <= 2'b00;
      uns_reg       <= 1'b0;
    end else begin
      rsp_valid_reg <= accept;
      if (accept) begin
        rsp_err_reg <= req_err;
        is_load_reg <= ~bus.req_we & ~req_err;
        size_reg    <= bus.req_size;
        off_reg     <= off;
        uns_reg     <= bus.req_uns;
      end
    end
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign sel_byte = rd_word[8*off_reg +: 8];
  assign sel_half = off_reg[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (size_reg)
      2'b00:   load_data = {{24{~uns_reg & sel_byte[7]}}, sel_byte};
      2'b01:   load_data = {{16{~uns_reg & sel_half[15]}}, sel_half};
      default: load_data = rd_word;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = is_load_reg ? load_data : 32'h0000_0000;

endmodule

// File: tb/tb_data_memory_lanes.sv
module tb_data_memory_lanes;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic clock;
  logic reset;
  int   checks;
  int   passed;
  int   cnt;

  data_memory_lanes_if bus ();

  data_memory_lanes #(.DEPTH(DEPTH), .AW(AW), .CLEAR_EN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %08h want %08h", tag, got, exp);
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
    chk({tag, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, ".err"},   {31'd0, bus.rsp_err}, {31'd0, exp_err});
    $display("txn %s: rdata=%08h err=%0b", tag, bus.rsp_rdata, bus.rsp_err);
  endtask

  // Present one request for one cycle; returns #1 after the accepting edge.
  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_uns   = uns;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Counts cycles with req_ready low from now, bounded.
  task automatic count_sweep(input string tag);
    cnt = 0;
    while (!bus.req_ready && cnt < 2000) begin
      @(posedge clock);
      #1;
      cnt++;
    end
    chk(tag, cnt, DEPTH);
    $display("txn %s: ready-low cycles=%0d", tag, cnt);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_uns   = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    // ---- T1: reset state, sweep length, all zero ----
    repeat (3) @(posedge clock);
    #1;
    chk("rst.ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst.valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst.rdata", bus.rsp_rdata, 32'd0);
    chk("rst.err",   {31'd0, bus.rsp_err}, 32'd0);
    reset = 1'b0;
    count_sweep("t1.sweep");
    for (int i = 0; i < DEPTH; i++) begin
      req(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      checks++;
      assert (bus.rsp_valid === 1'b1 && bus.rsp_rdata === 32'h0 && bus.rsp_err === 1'b0) passed++;
      else $error("FAIL t1.zero[%0d]: got v=%0b d=%08h e=%0b want v=1 d=00000000 e=0",
                  i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    idle();
    chk("t1.idle.valid", {31'd0, bus.rsp_valid}, 32'd0);

    // ---- T2: word store, byte merge, byte loads ----
    req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344); chk_rsp("t2.sw",  32'h0, 1'b0);
    req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA); chk_rsp("t2.sb",  32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);        chk_rsp("t2.lw",  32'h11AA3344, 1'b0);
    req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);        chk_rsp("t2.lb",  32'hFFFFFFAA, 1'b0);
    req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);        chk_rsp("t2.lbu", 32'h000000AA, 1'b0);
    req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);        chk_rsp("t2.lb0", 32'h00000044, 1'b0);

    // ---- T3: upper halfword store and halfword loads ----
    req(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001); chk_rsp("t3.sh",  32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);        chk_rsp("t3.lw",  32'h80010000, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);        chk_rsp("t3.lh",  32'hFFFF8001, 1'b0);
    req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);        chk_rsp("t3.lhu", 32'h00008001, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);        chk_rsp("t3.lh0", 32'h00000000, 1'b0);

    // ---- T4: misaligned / illegal size ----
    req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);        chk_rsp("t4.lw_mis",  32'h0, 1'b1);
    req(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000FFFF); chk_rsp("t4.sh_mis",  32'h0, 1'b1);
    req(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF); chk_rsp("t4.size11",  32'h0, 1'b1);
    req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);        chk_rsp("t4.lw_same", 32'h80010000, 1'b0);

    // ---- T5: store then load back-to-back, aliasing, hold behaviour ----
    req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF); chk_rsp("t5.sw",  32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);        chk_rsp("t5.lw",  32'hDEADBEEF, 1'b0);
    req(1'b1, 2'b10, 1'b0, 32'(32'h40 + 4 * DEPTH), 32'hCAFEF00D); chk_rsp("t5.sw_alias", 32'h0, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);        chk_rsp("t5.lw_alias", 32'hCAFEF00D, 1'b0);
    idle();
    chk("t5.hold.valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t5.hold.rdata", bus.rsp_rdata, 32'hCAFEF00D);

    // ---- T6: reset drops in-flight load, mid-sweep reset restarts sweep ----
    req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'h5A5A5A5A); chk_rsp("t6.sw_top", 32'h0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h40;
    reset = 1'b1;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    chk("t6.drop.valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t6.drop.rdata", bus.rsp_rdata, 32'h0);
    chk("t6.drop.ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    chk("t6.mid.ready", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    count_sweep("t6.sweep");
    for (int i = 0; i < DEPTH; i++) begin
      req(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0);
      checks++;
      assert (bus.rsp_valid === 1'b1 && bus.rsp_rdata === 32'h0 && bus.rsp_err === 1'b0) passed++;
      else $error("FAIL t6.zero[%0d]: got v=%0b d=%08h e=%0b want v=1 d=00000000 e=0",
                  i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    $display("txn t6.zero: swept %0d words", DEPTH);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
